// File: rtl/adc_sequencer.sv
// adc_sequencer: shares the MAX10 built-in ADC between the transceiver audio/mic path and the
//   CPU-read auxiliary channels, keeping exactly one single-conversion command outstanding.
// Latency: audio_out/audio_stb_out and aux_out/aux_stb_out update 1 clk after response_valid_in.
// Backpressure: the command holds stable in ISSUE until command_ready_in. Audio has no backpressure.
//   Aux results are held until aux_ack_in. A newer aux result that arrives while one is still
//   unacknowledged is dropped and counted in overflow_count_out.
//
// Ports:
//   clk, rst_n                        ADC clock, asynchronous active-low reset
//   enable_in                         run sequencing; on deassertion the in-flight conversion finishes
//   audio_channel_in, aux_mask_in     slot configuration, sampled only when a command is set up
//   command_*                         single-beat Avalon-ST command to the ADC IP
//   response_*                        Avalon-ST response from the ADC IP
//   audio_out, audio_stb_out          latest audio sample plus a one-cycle strobe
//   aux_out, aux_stb_out, aux_ack_in  CPU holding register {11'b0, ch[4:0], 4'b0, data[11:0]}
//   overflow_count_out                aux results dropped (saturating)
//   error_count_out                   unexpected, mismatched or timed-out responses (saturating)
//
// Optional: define ADC_SEQ_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES clk cycles.
// The TIMEOUT_CYCLES parameter only exists in that build.

module adc_sequencer #(
  parameter int AUDIO_RATIO    = 1,
  parameter int AUX_CHANNELS   = 8,
  parameter int AUX_BASE       = 1
`ifdef ADC_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_in,
  input  logic [4:0]              audio_channel_in,
  input  logic [AUX_CHANNELS-1:0] aux_mask_in,
  output logic                    command_valid_out,
  output logic [4:0]              command_channel_out,
  output logic                    command_startofpacket_out,
  output logic                    command_endofpacket_out,
  input  logic                    command_ready_in,
  input  logic                    response_valid_in,
  input  logic [4:0]              response_channel_in,
  input  logic [11:0]             response_data_in,
  output logic [11:0]             audio_out,
  output logic                    audio_stb_out,
  output logic [31:0]             aux_out,
  output logic                    aux_stb_out,
  input  logic                    aux_ack_in,
  output logic [7:0]              overflow_count_out,
  output logic [7:0]              error_count_out
);

  localparam int PTR_W = (AUX_CHANNELS > 1) ? $clog2(AUX_CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [3:0]       slot_cnt;     // audio conversions since the last aux conversion
  logic [PTR_W-1:0] rr_ptr;       // aux mask index where the next search starts
  logic [4:0]       cmd_chan;     // channel of the command in flight
  logic             cmd_aux;      // command in flight belongs to the aux requester

  logic             load_slot;
  logic             aux_found;
  logic [PTR_W-1:0] aux_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic [4:0]       aux_chan;
  logic             pick_aux;

  logic             resp_match;
  logic             route_audio;
  logic             route_aux;
  logic             err_inc;
  logic             timeout;

  // ------------------------------------------------------------------
  // Response watchdog
  // ------------------------------------------------------------------
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WD_W-1:0] wd_cnt;

  // wd_cnt is 0 in the first WAIT_RESP cycle, so the timeout fires in the
  // TIMEOUT_CYCLES-th silent cycle.
  assign timeout = (state == WAIT_RESP) && !response_valid_in &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != WAIT_RESP) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Aux round-robin search: first enabled channel at or after rr_ptr
  // ------------------------------------------------------------------
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    aux_found = 1'b0;
    aux_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < AUX_CHANNELS; k++) begin
      idx   = (int'(rr_ptr) + k) % AUX_CHANNELS;
      idx_w = PTR_W'(idx);
      if (!aux_found && aux_mask_in[idx_w]) begin
        aux_found = 1'b1;
        aux_idx   = idx_w;
      end
    end
  end

  assign ptr_nxt  = (int'(aux_idx) == AUX_CHANNELS - 1) ? '0 : aux_idx + PTR_W'(1);
  assign aux_chan = 5'(AUX_BASE + int'(aux_idx));
  // aux_found is low exactly when the mask is empty, which forces an audio slot.
  assign pick_aux = (int'(slot_cnt) >= AUDIO_RATIO) && aux_found;

  // ------------------------------------------------------------------
  // Response classification
  // ------------------------------------------------------------------
  assign resp_match  = (state == WAIT_RESP) && (response_channel_in == cmd_chan);
  assign route_audio = response_valid_in && resp_match && !cmd_aux;
  assign route_aux   = response_valid_in && resp_match && cmd_aux;
  // Anything outside WAIT_RESP, or on the wrong channel, is stray (late responses included).
  assign err_inc     = (response_valid_in && !resp_match) || timeout;

  // ------------------------------------------------------------------
  // FSM: next state and command outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt                 = state;
    command_valid_out         = 1'b0;
    command_startofpacket_out = 1'b0;
    command_endofpacket_out   = 1'b0;
    case (state)
      IDLE: begin
        if (enable_in) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Single-beat packet: SOP and EOP ride with valid.
        command_valid_out         = 1'b1;
        command_startofpacket_out = 1'b1;
        command_endofpacket_out   = 1'b1;
        if (command_ready_in) begin
          state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (response_valid_in || timeout) begin
          state_nxt = enable_in ? ISSUE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign command_channel_out = cmd_chan;

  // The slot is chosen on the edge that enters ISSUE; the channel then holds
  // stable for as long as the ADC stalls the command.
  assign load_slot = (state_nxt == ISSUE) && (state != ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      slot_cnt <= '0;
      rr_ptr   <= '0;
      cmd_chan <= '0;
      cmd_aux  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_slot) begin
        if (pick_aux) begin
          cmd_chan <= aux_chan;
          cmd_aux  <= 1'b1;
          rr_ptr   <= ptr_nxt;
          slot_cnt <= '0;
        end else begin
          cmd_chan <= audio_channel_in;
          cmd_aux  <= 1'b0;
          // Counting past AUDIO_RATIO changes nothing, so stop there instead of wrapping.
          if (int'(slot_cnt) < AUDIO_RATIO) begin
            slot_cnt <= slot_cnt + 4'd1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Result registers and counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_out          <= '0;
      audio_stb_out      <= 1'b0;
      aux_out            <= '0;
      aux_stb_out        <= 1'b0;
      overflow_count_out <= '0;
      error_count_out    <= '0;
    end else begin
      audio_stb_out <= route_audio;
      if (route_audio) begin
        audio_out <= response_data_in;
      end

      // An ack in the same cycle frees the register for the incoming result.
      if (route_aux && (!aux_stb_out || aux_ack_in)) begin
        aux_out     <= {11'b0, response_channel_in, 4'b0, response_data_in};
        aux_stb_out <= 1'b1;
      end else begin
        if (route_aux && (overflow_count_out != 8'hFF)) begin
          overflow_count_out <= overflow_count_out + 8'd1;
        end
        if (aux_ack_in) begin
          aux_stb_out <= 1'b0;
        end
      end

      if (err_inc && (error_count_out != 8'hFF)) begin
        error_count_out <= error_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: directed stimulus with an ADC responder, a transaction-level model of the
//   sequencer checked every cycle, and literal expectations at the end of each scenario.

module tb_adc_sequencer;

  localparam int AUDIO_RATIO  = 1;
  localparam int AUX_CHANNELS = 8;
  localparam int AUX_BASE     = 1;
  localparam int TO_CYCLES    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_in = 1'b0;
  logic [4:0]  audio_channel_in = '0;
  logic [7:0]  aux_mask_in = '0;
  logic        command_valid_out;
  logic [4:0]  command_channel_out;
  logic        command_startofpacket_out;
  logic        command_endofpacket_out;
  logic        command_ready_in = 1'b1;
  logic        response_valid_in = 1'b0;
  logic [4:0]  response_channel_in = '0;
  logic [11:0] response_data_in = '0;
  logic [11:0] audio_out;
  logic        audio_stb_out;
  logic [31:0] aux_out;
  logic        aux_stb_out;
  logic        aux_ack_in = 1'b0;
  logic [7:0]  overflow_count_out;
  logic [7:0]  error_count_out;

  always #5 clk = ~clk;

  adc_sequencer #(
    .AUDIO_RATIO   (AUDIO_RATIO),
    .AUX_CHANNELS  (AUX_CHANNELS),
    .AUX_BASE      (AUX_BASE)
`ifdef ADC_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO_CYCLES)
`endif
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .enable_in                (enable_in),
    .audio_channel_in         (audio_channel_in),
    .aux_mask_in              (aux_mask_in),
    .command_valid_out        (command_valid_out),
    .command_channel_out      (command_channel_out),
    .command_startofpacket_out(command_startofpacket_out),
    .command_endofpacket_out  (command_endofpacket_out),
    .command_ready_in         (command_ready_in),
    .response_valid_in        (response_valid_in),
    .response_channel_in      (response_channel_in),
    .response_data_in         (response_data_in),
    .audio_out                (audio_out),
    .audio_stb_out            (audio_stb_out),
    .aux_out                  (aux_out),
    .aux_stb_out              (aux_stb_out),
    .aux_ack_in               (aux_ack_in),
    .overflow_count_out       (overflow_count_out),
    .error_count_out          (error_count_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  // ------------------------------------------------------------------
  // Transaction-level model
  // ------------------------------------------------------------------
  bit          e_cmd_vld;   // a command is being offered to the ADC
  bit          e_wait;      // a conversion is outstanding
  logic [4:0]  e_cmd_ch;
  bit          e_cmd_aux;
  int          audio_run;   // audio slots issued since the last aux slot
  int          aux_next;    // mask index where the next aux search begins
  int          e_wait_n;
  logic [11:0] e_audio;
  bit          e_audio_stb;
  logic [31:0] e_aux;
  bit          e_aux_stb;
  int          e_ovf;
  int          e_err;

  task automatic model_reset();
    e_cmd_vld = 0; e_wait = 0; e_cmd_ch = '0; e_cmd_aux = 0;
    audio_run = 0; aux_next = 0; e_wait_n = 0;
    e_audio = '0; e_audio_stb = 0; e_aux = '0; e_aux_stb = 0; e_ovf = 0; e_err = 0;
  endtask

  task automatic pick_slot();
    if (aux_mask_in != 0 && audio_run >= AUDIO_RATIO) begin
      for (int k = 0; k < AUX_CHANNELS; k++) begin
        int idx = (aux_next + k) % AUX_CHANNELS;
        if (aux_mask_in[idx]) begin
          e_cmd_ch  = 5'(AUX_BASE + idx);
          e_cmd_aux = 1;
          aux_next  = (idx + 1) % AUX_CHANNELS;
          break;
        end
      end
      audio_run = 0;
    end else begin
      e_cmd_ch  = audio_channel_in;
      e_cmd_aux = 0;
      audio_run++;
    end
  endtask

  // Advance the model across the coming rising edge using the inputs as they stand now.
  task automatic model_step();
    bit start = 0;
    bit loaded = 0;
    bit to = 0;
    e_audio_stb = 0;
    if (response_valid_in) begin
      if (e_wait && response_channel_in == e_cmd_ch) begin
        if (!e_cmd_aux) begin
          e_audio = response_data_in;
          e_audio_stb = 1;
        end else if (e_aux_stb && !aux_ack_in) begin
          e_ovf = sat8(e_ovf + 1);
        end else begin
          e_aux = {11'b0, response_channel_in, 4'b0, response_data_in};
          loaded = 1;
        end
      end else begin
        e_err = sat8(e_err + 1);
      end
    end
    if (loaded) e_aux_stb = 1;
    else if (aux_ack_in) e_aux_stb = 0;
`ifdef ADC_SEQ_TIMEOUT_EN
    if (e_wait && !response_valid_in) begin
      if (e_wait_n == TO_CYCLES - 1) begin
        to = 1;
        e_err = sat8(e_err + 1);
      end
      e_wait_n++;
    end
`endif
    if (e_wait) begin
      if (response_valid_in || to) begin
        e_wait = 0;
        start = enable_in;
      end
    end else if (e_cmd_vld) begin
      if (command_ready_in) begin
        e_cmd_vld = 0;
        e_wait = 1;
        e_wait_n = 0;
      end
    end else if (enable_in) begin
      start = 1;
    end
    if (start) begin
      pick_slot();
      e_cmd_vld = 1;
    end
  endtask

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("cmd_valid", command_valid_out, e_cmd_vld);
    chk("cmd_sop", command_startofpacket_out, e_cmd_vld);
    chk("cmd_eop", command_endofpacket_out, e_cmd_vld);
    if (e_cmd_vld || !rst_n) chk("cmd_channel", command_channel_out, e_cmd_ch);
    chk("audio_stb", audio_stb_out, e_audio_stb);
    chk("audio_out", audio_out, e_audio);
    chk("aux_stb", aux_stb_out, e_aux_stb);
    chk("aux_out", aux_out, e_aux);
    chk("overflow_count", overflow_count_out, e_ovf);
    chk("error_count", error_count_out, e_err);
    if (rst_n) model_step();
  end

  // ------------------------------------------------------------------
  // ADC responder and per-cycle stimulus driver
  // ------------------------------------------------------------------
  bit          auto_rsp = 1;
  int          rsp_delay = 1;
  logic [11:0] rsp_data = 12'h123;
  bit          rsp_incr = 0;
  bit          bad_once = 0;
  bit          ack_with_aux = 0;
  logic        aux_ack_hold = 1'b0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [4:0]  pend_ch = '0;
  int          rsp_count = 0;
  bit          inj_now = 0;
  logic [4:0]  inj_ch = '0;
  logic [11:0] inj_data = '0;
  int          n_acc = 0;
  int          n_vld_seen = 0;
  int          n_audio_stb = 0;
  logic [4:0]  acc_log[$];

  task automatic cycle();
    bit         acc;
    bit         drove;
    logic [4:0] ch;
    logic [4:0] rch;
    @(negedge clk);
    acc = command_valid_out && command_ready_in;
    ch  = command_channel_out;
    if (command_valid_out) n_vld_seen++;
    if (audio_stb_out) n_audio_stb++;
    if (acc) begin
      n_acc++;
      acc_log.push_back(ch);
    end
    @(posedge clk);
    #1;
    drove = 0;
    rch = '0;
    response_valid_in = 1'b0;
    if (acc && auto_rsp && rst_n) begin
      pend = 1;
      pend_cnt = rsp_delay;
      pend_ch = ch;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        pend = 0;
        drove = 1;
        rch = bad_once ? 5'd7 : pend_ch;
        bad_once = 0;
        response_valid_in = 1'b1;
        response_channel_in = rch;
        response_data_in = rsp_incr ? 12'(12'h100 + rsp_count) : rsp_data;
        rsp_count++;
      end else begin
        pend_cnt--;
      end
    end
    if (inj_now) begin
      inj_now = 0;
      response_valid_in = 1'b1;
      response_channel_in = inj_ch;
      response_data_in = inj_data;
    end
    aux_ack_in = aux_ack_hold | (ack_with_aux && drove && rch != audio_channel_in);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend = 0; inj_now = 0; bad_once = 0; ack_with_aux = 0; aux_ack_hold = 1'b0;
    enable_in = 1'b0; command_ready_in = 1'b1; response_valid_in = 1'b0; aux_ack_in = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    acc_log.delete();
    n_acc = 0; rsp_count = 0; n_vld_seen = 0; n_audio_stb = 0;
  endtask

  task automatic wait_rsp(input string name, input int target, input int budget);
    int g = 0;
    while (rsp_count < target && g < budget) begin
      cycle();
      g++;
    end
    chk(name, (rsp_count < target), 0);
  endtask

  initial begin
    int nz;
    logic [4:0] exp_seq [8];
    exp_seq = '{5'd0, 5'd1, 5'd0, 5'd3, 5'd0, 5'd1, 5'd0, 5'd3};

    // Reset state
    do_reset();
    chk("reset_cmd_valid", command_valid_out, 0);
    chk("reset_aux_out", aux_out, 0);
    chk("reset_error_count", error_count_out, 0);

    // Mask empty: audio only, echoed data 0x123
    audio_channel_in = 5'd0; aux_mask_in = 8'h00; rsp_data = 12'h123; rsp_incr = 0;
    enable_in = 1'b1;
    cycles(40);
    nz = 0;
    foreach (acc_log[i]) if (acc_log[i] != 5'd0) nz++;
    chk("audio_only_nonzero_ch", nz, 0);
    chk("audio_only_cmds_seen", (n_acc >= 5), 1);
    chk("audio_only_stb_seen", (n_audio_stb >= 5), 1);
    chk("audio_only_data", audio_out, 12'h123);
    chk("audio_only_aux_stb", aux_stb_out, 0);

    // Round robin with mask 0000_0101 and AUX_BASE 1
    do_reset();
    aux_mask_in = 8'b0000_0101; aux_ack_hold = 1'b1; enable_in = 1'b1;
    wait_rsp("rr_wait", 8, 200);
    chk("rr_count", (acc_log.size() >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_log.size()) chk($sformatf("rr_seq[%0d]", i), acc_log[i], exp_seq[i]);
    end

    // Stalled command: valid and channel held for 10 cycles, then exactly one accept
    do_reset();
    aux_mask_in = 8'h00; audio_channel_in = 5'd9; command_ready_in = 1'b0; enable_in = 1'b1;
    cycles(2);
    n_vld_seen = 0;
    audio_channel_in = 5'd4;
    cycles(10);
    chk("stall_valid_cycles", n_vld_seen, 10);
    chk("stall_no_accept", n_acc, 0);
    chk("stall_channel", command_channel_out, 5'd9);
    command_ready_in = 1'b1; enable_in = 1'b0;
    cycle();
    command_ready_in = 1'b0;
    cycles(8);
    chk("stall_one_accept", n_acc, 1);
    chk("stall_back_idle", command_valid_out, 0);

    // Aux overflow, then ack coinciding with a new result
    do_reset();
    aux_mask_in = 8'b0000_0001; audio_channel_in = 5'd0; rsp_incr = 1; enable_in = 1'b1;
    wait_rsp("ovf_wait", 4, 100);
    cycle();
    chk("ovf_aux_kept", aux_out, 32'h0001_0101);
    chk("ovf_count", overflow_count_out, 1);
    chk("ovf_stb", aux_stb_out, 1);
    ack_with_aux = 1;
    wait_rsp("ack_wait", 6, 100);
    cycle();
    chk("ack_aux_new", aux_out, 32'h0001_0105);
    chk("ack_ovf_count", overflow_count_out, 1);
    chk("ack_stb", aux_stb_out, 1);
    ack_with_aux = 0; rsp_incr = 0;

    // Wrong response channel
    do_reset();
    aux_mask_in = 8'h00; audio_channel_in = 5'd0; rsp_data = 12'h456; bad_once = 1; enable_in = 1'b1;
    wait_rsp("mis_wait", 1, 50);
    cycle();
    chk("mis_error", error_count_out, 1);
    chk("mis_no_audio_stb", n_audio_stb, 0);
    wait_rsp("mis_cont_wait", 4, 100);
    cycle();
    chk("mis_continue_err", error_count_out, 1);
    chk("mis_continue_audio", audio_out, 12'h456);

    // Reset while a conversion is outstanding, then the late response
    auto_rsp = 0;
    begin
      int g = 0;
      int a0 = n_acc;
      while (n_acc == a0 && g < 20) begin
        cycle();
        g++;
      end
      chk("rwait_accept", (n_acc > a0), 1);
    end
    cycles(3);
    do_reset();
    chk("rmid_audio", audio_out, 0);
    chk("rmid_error", error_count_out, 0);
    chk("rmid_valid", command_valid_out, 0);
    inj_ch = 5'd0; inj_data = 12'hABC; inj_now = 1;
    cycles(2);
    chk("late_rsp_error", error_count_out, 1);
    chk("late_rsp_no_audio", audio_out, 0);

`ifdef ADC_SEQ_TIMEOUT_EN
    // Watchdog: responses suppressed, error count climbs and saturates
    do_reset();
    auto_rsp = 0; aux_mask_in = 8'h00; enable_in = 1'b1;
    cycles(60);
    chk("to_error_progress", (error_count_out >= 2 && error_count_out <= 4), 1);
    cycles(17 * 260);
    chk("to_error_sat", error_count_out, 8'hFF);
    cycles(5);
    do_reset();
    chk("to_reset_error", error_count_out, 0);
    chk("to_reset_valid", command_valid_out, 0);
    auto_rsp = 1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Schedules the MAX10 built-in ADC between two requesters: the transceiver audio/mic path and the spare auxiliary channels read by the control CPU.
- Issues single-conversion command packets, tracks the one outstanding conversion, and routes each response either to the audio stream or to a CPU holding register.
- Sits between the ADC IP command/response interface and the transceiver/CPU buses, in the ADC clock domain.

Parameters:
- AUDIO_RATIO, 1, audio conversions issued before each aux conversion (1..15).
- AUX_CHANNELS, 8, number of aux channels selectable by aux_mask_in.
- AUX_BASE, 1, ADC channel number of aux_mask_in bit 0.
- TIMEOUT_CYCLES, 255, response watchdog length in clk cycles (optional feature only).

Ports:
- clk  in  1  ADC/system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable_in  in  1  run sequencing.
- audio_channel_in  in  5  ADC channel for audio conversions.
- aux_mask_in  in  AUX_CHANNELS  bit i enables channel AUX_BASE+i.
- command_valid_out  out  1  ADC command valid.
- command_channel_out  out  5  ADC command channel.
- command_startofpacket_out  out  1  ADC command start of packet.
- command_endofpacket_out  out  1  ADC command end of packet.
- command_ready_in  in  1  ADC accepts command.
- response_valid_in  in  1  ADC response valid.
- response_channel_in  in  5  ADC response channel.
- response_data_in  in  12  ADC response sample.
- audio_out  out  12  latest audio sample.
- audio_stb_out  out  1  one-cycle audio strobe, no backpressure.
- aux_out  out  32  {11'b0, channel[4:0], 4'b0, data[11:0]}.
- aux_stb_out  out  1  aux data valid.
- aux_ack_in  in  1  CPU consumes aux data.
- overflow_count_out  out  8  aux results dropped, saturating.
- error_count_out  out  8  unexpected or mismatched responses, saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; audio slot counter 0; round-robin pointer 0.
- States and transitions:
  - IDLE: when enable_in=1, go to ISSUE on the next cycle.
  - ISSUE: command_valid_out=1, startofpacket=1 and endofpacket=1 together; channel is latched on entry and held stable. When command_valid_out=1 and command_ready_in=1, deassert valid the following cycle and go to WAIT_RESP.
  - WAIT_RESP: wait for response_valid_in. Then go to ISSUE if enable_in=1, otherwise IDLE.
- Slot selection, done on entry to ISSUE; audio_channel_in and aux_mask_in are sampled only at this point:
  - If the slot counter is below AUDIO_RATIO, or aux_mask_in==0, issue audio_channel_in and increment the counter.
  - Otherwise issue an aux channel: the first set mask bit at or after the pointer, wrapping modulo AUX_CHANNELS. Set the pointer to that index+1 (with wrap) and clear the counter.
- First command after reset is always audio.
- Response routing:
  - If response_channel_in equals the issued channel, route it. Audio: audio_out<=data and audio_stb_out=1 for one cycle, with 1-cycle latency from response_valid_in.
  - Otherwise discard it and increment error_count_out.
- response_valid_in in IDLE or ISSUE: discard it and increment error_count_out.
- Aux holding register:
  - On a routed aux result, load aux_out and set aux_stb_out.
  - aux_stb_out stays high until aux_ack_in=1 is sampled.
  - New result while stb=1 and no ack: drop the new result, keep the old one, increment overflow_count_out.
  - New result in the same cycle as an ack: load the new result, stb stays 1, no overflow.
- Counters saturate at 255 and clear only on reset.
- enable_in falling: any outstanding command or conversion completes normally, then the block goes to IDLE. A command in ISSUE is not withdrawn.
- Reset asserted mid-operation: immediate return to reset values. A late response after reset is counted as an error.

Optional Feature:
- Macro ADC_SEQ_TIMEOUT_EN.
- Defined: WAIT_RESP runs a watchdog counter. If TIMEOUT_CYCLES elapse without a response, the block increments error_count_out and goes to ISSUE (or IDLE if disabled). A response arriving after the timeout is counted as an error.
- Undefined: WAIT_RESP waits indefinitely and no watchdog logic is present.

Test Plan:
- Mask=0, audio ch 0, ready always 1, ADC model echoes channel with data 0x123 → only ch 0 commands; audio_stb_out pulses, audio_out=0x123; aux_stb_out stays 0.
- AUDIO_RATIO=1, mask=8'b0000_0101, AUX_BASE=1 → command channel order 0,1,0,3,0,1,0,3.
- command_ready_in held low 10 cycles → command_valid_out and channel stable for all 10 cycles; exactly one command accepted.
- Aux result pending with no ack, second aux result arrives → aux_out keeps first result, overflow_count_out=1. Then an ack in the same cycle as a new result → new result loaded, count stays 1.
- Response with channel 7 when channel 0 was issued → no strobes, error_count_out=1, sequencing continues.
- Macro defined, TIMEOUT_CYCLES=16, responses suppressed → error_count_out increments every ~17 cycles and saturates at 255. Reset mid-WAIT_RESP → all outputs return to 0.
